eth_decap: RTL and testbench

//  RX counterpart of the NetTLP TX encapsulator. Accepts 64-bit AXIS Ethernet frames from the MAC RX path.

---
 rtl/eth_decap.sv | 221 ++++++++++++++++++++++
 tb/tb_eth_decap.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_decap.sv
// eth_decap: NetTLP RX decapsulator. Filters the Eth/IPv4/UDP/NetTLP header, strips it and writes
// the word-swapped TLP payload into the RX FIFO. Optional IPv4 header checksum check: NETTLP_RX_IPCHECK_EN.
module eth_decap #(
    parameter logic [15:0] udp_dport    = 16'h3000,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        eth_clk,
    input  logic        eth_rst_n,
    input  logic        eth_tvalid,
    input  logic        eth_tlast,
    input  logic [7:0]  eth_tkeep,
    input  logic [63:0] eth_tdata,
    input  logic        eth_tuser,
    output logic        wr_en,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_keep,
    output logic        wr_last,
    output logic        wr_user,
    output logic [15:0] wr_len,
    output logic [7:0]  wr_tag,
    input  logic        full,
    input  logic        prog_full,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] peer_ip,
    output logic [31:0] cnt_ok,
    output logic [31:0] cnt_drop
);

    // state   | meaning
    // S_HDR   | collecting header beats 0..5, match decided at beat 5
    // S_DATA  | forwarding TLP beats to the FIFO
    // S_DROP  | discarding a rejected frame until tlast
    // S_ABORT | FIFO overflowed mid-TLP; discard input, then write error terminator
    typedef enum logic [1:0] {S_HDR, S_DATA, S_DROP, S_ABORT} state_t;

    state_t      r_state;
    logic [2:0]  r_beat;
    logic        r_in_frame;
    logic [47:0] r_dmac;
    logic [15:0] r_type;
    logic [7:0]  r_verihl;
    logic [7:0]  r_proto;
    logic [31:0] r_saddr;
    logic [31:0] r_daddr;
    logic [15:0] r_dport;
    logic [15:0] r_ulen;

    logic [7:0]  w_b [8];
    logic [63:0] w_swap;
    logic        w_dmac_ok;
    logic        w_csum_ok;
    logic        w_match;
    logic        w_term;
    logic        w_hdr_beat;
    logic        w_runt;
    logic        w_reject;
    logic        w_accept;
    logic [1:0]  w_drop_inc;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_b[j] = eth_tdata[8*j +: 8];
        end
    end

    assign w_swap = {w_b[4], w_b[5], w_b[6], w_b[7], w_b[0], w_b[1], w_b[2], w_b[3]};

`ifdef NETTLP_RX_IPCHECK_EN
    logic [19:0] r_csum_acc;
    logic [19:0] w_csum_add;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // IP header spans byte 14 (beat 1) through byte 33 (beat 4)
    always_comb begin
        w_csum_add = 20'd0;
        case (r_beat)
            3'd1: w_csum_add = {4'd0, w_b[6], w_b[7]};
            3'd2, 3'd3: w_csum_add = {4'd0, w_b[0], w_b[1]} + {4'd0, w_b[2], w_b[3]}
                                   + {4'd0, w_b[4], w_b[5]} + {4'd0, w_b[6], w_b[7]};
            3'd4: w_csum_add = {4'd0, w_b[0], w_b[1]};
            default: w_csum_add = 20'd0;
        endcase
    end

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_csum_acc <= 20'd0;
        end else if (w_hdr_beat) begin
            r_csum_acc <= (r_beat == 3'd0) ? 20'd0 : r_csum_acc + w_csum_add;
        end
    end

    assign w_fold1   = {1'b0, r_csum_acc[15:0]} + {13'd0, r_csum_acc[19:16]};
    assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};
    assign w_csum_ok = (w_fold2 == 16'hFFFF);
`else
    assign w_csum_ok = 1'b1;
`endif

    assign w_dmac_ok = (r_dmac == local_mac) || (ACCEPT_BCAST && (r_dmac == 48'hFFFF_FFFF_FFFF));
    assign w_match   = w_dmac_ok && (r_type == 16'h0800) && (r_verihl == 8'h45) && (r_proto == 8'd17)
                    && (r_saddr == peer_ip) && (r_daddr == local_ip)
                    && (r_dport[15:8] == udp_dport[15:8]) && (r_ulen >= 16'd15) && w_csum_ok;

    // The terminator slot doubles as beat 0 of a frame arriving in the same cycle
    assign w_term     = (r_state == S_ABORT) && !r_in_frame && !full;
    assign w_hdr_beat = eth_tvalid && ((r_state == S_HDR) || w_term);
    assign w_runt     = w_hdr_beat && eth_tlast;
    assign w_accept   = w_hdr_beat && !eth_tlast && (r_beat == 3'd5) && w_match && !prog_full;
    assign w_reject   = w_hdr_beat && !eth_tlast && (r_beat == 3'd5) && !(w_match && !prog_full);
    assign w_drop_inc = {1'b0, w_term} + {1'b0, w_runt} + {1'b0, w_reject};

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_state    <= S_HDR;
            r_beat     <= 3'd0;
            r_in_frame <= 1'b0;
            r_dmac     <= 48'd0;
            r_type     <= 16'd0;
            r_verihl   <= 8'd0;
            r_proto    <= 8'd0;
            r_saddr    <= 32'd0;
            r_daddr    <= 32'd0;
            r_dport    <= 16'd0;
            r_ulen     <= 16'd0;
            wr_en      <= 1'b0;
            wr_data    <= 64'd0;
            wr_keep    <= 8'd0;
            wr_last    <= 1'b0;
            wr_user    <= 1'b0;
            wr_len     <= 16'd0;
            wr_tag     <= 8'd0;
            cnt_ok     <= 32'd0;
            cnt_drop   <= 32'd0;
        end else begin
            wr_en    <= 1'b0;
            cnt_drop <= cnt_drop + {30'd0, w_drop_inc};

            case (r_state)
                S_DATA: begin
                    if (eth_tvalid) begin
                        if (full) begin
                            r_state    <= S_ABORT;
                            r_in_frame <= !eth_tlast;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= w_swap;
                            wr_keep <= eth_tkeep;
                            wr_last <= eth_tlast;
                            wr_user <= eth_tlast & eth_tuser;
                            if (eth_tlast) begin
                                cnt_ok  <= cnt_ok + 32'd1;
                                r_state <= S_HDR;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (eth_tvalid && eth_tlast) begin
                        r_state <= S_HDR;
                    end
                end
                S_ABORT: begin
                    if (w_term) begin
                        wr_en   <= 1'b1;
                        wr_data <= 64'd0;
                        wr_keep <= 8'd0;
                        wr_last <= 1'b1;
                        wr_user <= 1'b1;
                        r_state <= S_HDR;
                    end else if (r_in_frame) begin
                        if (eth_tvalid && eth_tlast) begin
                            r_in_frame <= 1'b0;
                        end
                    end else if (eth_tvalid) begin
                        r_in_frame <= !eth_tlast;
                    end
                end
                default: ;
            endcase

            if (w_hdr_beat) begin
                case (r_beat)
                    3'd0: r_dmac <= {w_b[0], w_b[1], w_b[2], w_b[3], w_b[4], w_b[5]};
                    3'd1: begin
                        r_type   <= {w_b[4], w_b[5]};
                        r_verihl <= w_b[6];
                    end
                    3'd2: r_proto <= w_b[7];
                    3'd3: begin
                        r_saddr         <= {w_b[2], w_b[3], w_b[4], w_b[5]};
                        r_daddr[31:16]  <= {w_b[6], w_b[7]};
                    end
                    3'd4: begin
                        r_daddr[15:0] <= {w_b[0], w_b[1]};
                        r_dport       <= {w_b[4], w_b[5]};
                        r_ulen        <= {w_b[6], w_b[7]};
                    end
                    default: ;
                endcase

                if (eth_tlast || (r_beat == 3'd5)) begin
                    r_beat <= 3'd0;
                end else begin
                    r_beat <= r_beat + 3'd1;
                end

                if (w_accept) begin
                    r_state <= S_DATA;
                    wr_len  <= r_ulen - 16'd14;
                    wr_tag  <= r_dport[7:0] - udp_dport[7:0];
                end else if (w_reject) begin
                    r_state <= S_DROP;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_decap.sv
// tb_eth_decap: table-driven filter vectors, hand-written overflow/runt sequences and randomized
// frames checked against a byte-level frame model of eth_decap.
module tb_eth_decap;
    localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
    localparam logic [31:0] LIP = 32'h0A00_0001;
    localparam logic [31:0] PIP = 32'h0A00_0002;

    logic        eth_clk = 1'b0;
    logic        eth_rst_n = 1'b0;
    logic        eth_tvalid = 1'b0, eth_tlast = 1'b0, eth_tuser = 1'b0;
    logic [7:0]  eth_tkeep = 8'd0;
    logic [63:0] eth_tdata = 64'd0;
    logic        full = 1'b0, prog_full = 1'b0;
    logic        wr_en, wr_last, wr_user;
    logic [63:0] wr_data;
    logic [7:0]  wr_keep, wr_tag;
    logic [15:0] wr_len;
    logic [31:0] cnt_ok, cnt_drop;

    always #5 eth_clk = ~eth_clk;

    eth_decap dut (
        .eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .eth_tvalid(eth_tvalid), .eth_tlast(eth_tlast),
        .eth_tkeep(eth_tkeep), .eth_tdata(eth_tdata), .eth_tuser(eth_tuser),
        .wr_en(wr_en), .wr_data(wr_data), .wr_keep(wr_keep), .wr_last(wr_last), .wr_user(wr_user),
        .wr_len(wr_len), .wr_tag(wr_tag), .full(full), .prog_full(prog_full),
        .local_mac(MAC), .local_ip(LIP), .peer_ip(PIP), .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
    );

    typedef struct {
        logic [63:0] d; logic [7:0] k; logic l; logic u; logic [15:0] len; logic [7:0] tag;
    } wr_t;

    typedef struct {
        logic [47:0] dmac; logic [15:0] etype; logic [7:0] verihl; logic [7:0] proto;
        logic [31:0] saddr; logic [31:0] daddr; logic [15:0] dport; logic [15:0] ulen;
        int plen; bit bad_csum;
    } hdr_t;

    typedef struct { string name; int mod; bit fwd; logic [7:0] tag; logic [15:0] len; } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] frm[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         m_ok = 0;
    int         m_drop = 0;

    always @(negedge eth_clk) begin
        if (eth_rst_n && wr_en) got_q.push_back('{wr_data, wr_keep, wr_last, wr_user, wr_len, wr_tag});
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
        check({name, " cnt_ok"}, 128'(cnt_ok), 128'(m_ok));
        check({name, " cnt_drop"}, 128'(cnt_drop), 128'(m_drop));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge eth_clk);
    endtask

    function automatic hdr_t base_hdr();
        hdr_t h;
        h.dmac = MAC; h.etype = 16'h0800; h.verihl = 8'h45; h.proto = 8'd17;
        h.saddr = PIP; h.daddr = LIP; h.dport = 16'h3005; h.ulen = 16'd30;
        h.plen = 16; h.bad_csum = 1'b0;
        return h;
    endfunction

    function automatic hdr_t apply_mod(input hdr_t h, input int m);
        hdr_t r = h;
        case (m)
            1:  r.daddr = LIP ^ 32'h1;
            2:  r.dmac = 48'hFFFF_FFFF_FFFF;
            3:  r.dmac = MAC ^ 48'h1;
            4:  r.etype = 16'h86DD;
            5:  r.verihl = 8'h46;
            6:  r.proto = 8'd6;
            7:  r.saddr = PIP ^ 32'h100;
            8:  r.dport = 16'h3105;
            9:  r.dport = 16'h30FF;
            10: r.ulen = 16'd14;
            11: r.ulen = 16'd15;
            12: r.dport = 16'h2F05;
            default: ;
        endcase
        return r;
    endfunction

    task automatic build(input hdr_t h, input bit seq_pay);
        logic [7:0]  ip [20];
        logic [15:0] tot, cs;
        int          s;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(h.dmac[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'hA0 + 8'(i));
        frm.push_back(h.etype[15:8]); frm.push_back(h.etype[7:0]);
        tot = 16'd20 + h.ulen;
        ip[0] = h.verihl; ip[1] = 8'h00; ip[2] = tot[15:8]; ip[3] = tot[7:0];
        ip[4] = 8'($urandom); ip[5] = 8'($urandom); ip[6] = 8'h00; ip[7] = 8'h00;
        ip[8] = 8'd64; ip[9] = h.proto; ip[10] = 8'h00; ip[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ip[12+i] = h.saddr[8*(3-i) +: 8];
            ip[16+i] = h.daddr[8*(3-i) +: 8];
        end
        s = 0;
        for (int i = 0; i < 20; i += 2) s += int'({ip[i], ip[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        if (h.bad_csum) cs = cs + 16'd1;
        ip[10] = cs[15:8]; ip[11] = cs[7:0];
        for (int i = 0; i < 20; i++) frm.push_back(ip[i]);
        frm.push_back(8'hC0); frm.push_back(8'h00);
        frm.push_back(h.dport[15:8]); frm.push_back(h.dport[7:0]);
        frm.push_back(h.ulen[15:8]); frm.push_back(h.ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        for (int i = 0; i < h.plen; i++) frm.push_back(seq_pay ? 8'(i) : 8'($urandom));
    endtask

    // Frame-level reference: decide from byte offsets whether the frame is forwarded
    function automatic bit model_accept(input bit pf);
        logic [47:0] dm;
        logic [15:0] ul;
        int          s;
        if (frm.size() <= 48) return 1'b0;
        if (pf) return 1'b0;
        dm = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        ul = {frm[38], frm[39]};
        if (dm != MAC && dm != 48'hFFFF_FFFF_FFFF) return 1'b0;
        if ({frm[12], frm[13]} != 16'h0800) return 1'b0;
        if (frm[14] != 8'h45 || frm[23] != 8'd17) return 1'b0;
        if ({frm[26], frm[27], frm[28], frm[29]} != PIP) return 1'b0;
        if ({frm[30], frm[31], frm[32], frm[33]} != LIP) return 1'b0;
        if (frm[36] != 8'h30 || ul < 16'd15) return 1'b0;
`ifdef NETTLP_RX_IPCHECK_EN
        s = 0;
        for (int i = 14; i < 34; i += 2) s += int'({frm[i], frm[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        if (s != 32'hFFFF) return 1'b0;
`else
        s = 0;
`endif
        return 1'b1;
    endfunction

    task automatic model_writes(input bit tuser);
        int          nb = (frm.size() + 7) / 8;
        logic [15:0] ul = {frm[38], frm[39]};
        for (int b = 6; b < nb; b++) begin
            wr_t w;
            w.d = 64'd0; w.k = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (8*b + j < frm.size()) begin
                    int k = (j < 4) ? 3 - j : 11 - j;
                    w.k[j] = 1'b1;
                    w.d[8*k +: 8] = frm[8*b + j];
                end
            end
            w.l = (b == nb - 1); w.u = w.l & tuser;
            w.len = ul - 16'd14; w.tag = frm[37];
            exp_q.push_back(w);
        end
    endtask

    function automatic wr_t term_beat();
        wr_t w;
        w.d = 64'd0; w.k = 8'd0; w.l = 1'b1; w.u = 1'b1; w.len = 16'd0; w.tag = 8'd0;
        return w;
    endfunction

    task automatic compare_writes(input string name);
        check({name, " write count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (exp_q[i].k == 8'd0)
                check($sformatf("%s term %0d", name, i), 128'({got_q[i].k, got_q[i].l, got_q[i].u}),
                      128'({exp_q[i].k, exp_q[i].l, exp_q[i].u}));
            else
                check($sformatf("%s beat %0d", name, i),
                      128'({got_q[i].d, got_q[i].k, got_q[i].l, got_q[i].u, got_q[i].len, got_q[i].tag}),
                      128'({exp_q[i].d, exp_q[i].k, exp_q[i].l, exp_q[i].u, exp_q[i].len, exp_q[i].tag}));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Drive the current frame; full rises at beat full_at and falls at beat clear_at (-1: untouched)
    task automatic send(input bit tuser, input int full_at, input int clear_at, input bit gaps);
        int nb = (frm.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                eth_tvalid = 1'b0;
                @(negedge eth_clk);
            end
            if (b == full_at) full = 1'b1;
            if (b == clear_at) full = 1'b0;
            eth_tvalid = 1'b1;
            eth_tlast  = (b == nb - 1);
            eth_tuser  = tuser & eth_tlast;
            for (int j = 0; j < 8; j++) begin
                eth_tkeep[j]        = (8*b + j < frm.size());
                eth_tdata[8*j +: 8] = eth_tkeep[j] ? frm[8*b + j] : 8'h00;
            end
            @(negedge eth_clk);
        end
        eth_tvalid = 1'b0; eth_tlast = 1'b0; eth_tuser = 1'b0; eth_tkeep = 8'd0; eth_tdata = 64'd0;
    endtask

    vec_t vecs[13];

    initial begin
        hdr_t h;
        bit   pf, tu, acc;

        vecs[0]  = '{"good",       0, 1'b1, 8'h05, 16'd16};
        vecs[1]  = '{"bad_lip",    1, 1'b0, 8'h00, 16'd0};
        vecs[2]  = '{"bcast",      2, 1'b1, 8'h05, 16'd16};
        vecs[3]  = '{"bad_dmac",   3, 1'b0, 8'h00, 16'd0};
        vecs[4]  = '{"bad_type",   4, 1'b0, 8'h00, 16'd0};
        vecs[5]  = '{"bad_verihl", 5, 1'b0, 8'h00, 16'd0};
        vecs[6]  = '{"bad_proto",  6, 1'b0, 8'h00, 16'd0};
        vecs[7]  = '{"bad_saddr",  7, 1'b0, 8'h00, 16'd0};
        vecs[8]  = '{"dport_hi",   8, 1'b0, 8'h00, 16'd0};
        vecs[9]  = '{"tag_ff",     9, 1'b1, 8'hFF, 16'd16};
        vecs[10] = '{"ulen14",    10, 1'b0, 8'h00, 16'd0};
        vecs[11] = '{"ulen15",    11, 1'b1, 8'h05, 16'd1};
        vecs[12] = '{"dport_lo",  12, 1'b0, 8'h00, 16'd0};

        idle(3);
        check("rst wr_en", 128'(wr_en), 128'(0));
        check("rst wr_len/tag", 128'({wr_len, wr_tag}), 128'(0));
        check("rst wr_last/user/keep", 128'({wr_last, wr_user, wr_keep}), 128'(0));
        check_cnt("rst");
        eth_rst_n = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            build(apply_mod(base_hdr(), vecs[i].mod), 1'b0);
            send(1'b0, -1, -1, 1'b0);
            idle(3);
            check({vecs[i].name, " fwd writes"}, 128'(got_q.size()), vecs[i].fwd ? 128'(2) : 128'(0));
            if (vecs[i].fwd && got_q.size() > 0)
                check({vecs[i].name, " len/tag"}, 128'({got_q[0].len, got_q[0].tag}),
                      128'({vecs[i].len, vecs[i].tag}));
            if (vecs[i].fwd) begin
                model_writes(1'b0);
                m_ok++;
            end else begin
                m_drop++;
            end
            compare_writes(vecs[i].name);
            check_cnt(vecs[i].name);
        end

        build(base_hdr(), 1'b1);
        send(1'b0, -1, -1, 1'b0);
        idle(3);
        m_ok++;
        if (got_q.size() == 2) begin
            check("byteorder beat0", 128'(got_q[0].d), 128'(64'h0405_0607_0001_0203));
            check("byteorder beat1", 128'(got_q[1].d), 128'(64'h0C0D_0E0F_0809_0A0B));
        end else begin
            check("byteorder count", 128'(got_q.size()), 128'(2));
        end
        got_q.delete();
        check_cnt("byteorder");

        h = base_hdr(); h.plen = 32; h.ulen = 16'd46;
        build(h, 1'b0);
        model_writes(1'b0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        send(1'b0, 7, -1, 1'b0);
        idle(4);
        compare_writes("full_mid pre");
        full = 1'b0;
        for (int t = 0; t < 10 && got_q.size() == 0; t++) @(negedge eth_clk);
        exp_q.push_back(term_beat());
        idle(2);
        m_drop++;
        compare_writes("full_mid term");
        check_cnt("full_mid");

        build(base_hdr(), 1'b0);
        model_writes(1'b0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        send(1'b1, 7, -1, 1'b0);
        idle(3);
        full = 1'b0;
        exp_q.push_back(term_beat());
        idle(4);
        m_drop++;
        compare_writes("last_full");
        check_cnt("last_full");

        h = base_hdr(); h.plen = 32; h.ulen = 16'd46;
        build(h, 1'b0);
        model_writes(1'b0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_q.push_back(term_beat());
        send(1'b0, 7, -1, 1'b0);
        idle(3);
        build(base_hdr(), 1'b0);
        model_writes(1'b0);
        send(1'b0, -1, 0, 1'b0);
        idle(4);
        m_drop++; m_ok++;
        compare_writes("term_coincide");
        check_cnt("term_coincide");

        build(base_hdr(), 1'b0);
        while (frm.size() > 32) void'(frm.pop_back());
        send(1'b0, -1, -1, 1'b0);
        build(base_hdr(), 1'b0);
        prog_full = 1'b1;
        send(1'b0, -1, -1, 1'b0);
        prog_full = 1'b0;
        idle(3);
        m_drop += 2;
        compare_writes("runt+prog_full");
        check_cnt("runt+prog_full");
        build(base_hdr(), 1'b0);
        model_writes(1'b0);
        send(1'b0, -1, -1, 1'b0);
        idle(3);
        m_ok++;
        compare_writes("after runt");
        check_cnt("after runt");

        h = base_hdr(); h.bad_csum = 1'b1;
        build(h, 1'b0);
        send(1'b0, -1, -1, 1'b0);
        idle(3);
`ifdef NETTLP_RX_IPCHECK_EN
        m_drop++;
`else
        model_writes(1'b0);
        m_ok++;
`endif
        compare_writes("bad_csum");
        check_cnt("bad_csum");

        for (int n = 0; n < 40; n++) begin
            h = base_hdr();
            h.plen = $urandom_range(1, 40);
            h.ulen = 16'(h.plen + 14);
            h.dport = {8'h30, 8'($urandom)};
            if ($urandom_range(0, 3) == 0) h = apply_mod(h, $urandom_range(1, 12));
            pf = ($urandom_range(0, 9) == 0);
            tu = ($urandom_range(0, 9) == 0);
            build(h, 1'b0);
            if ($urandom_range(0, 9) == 0)
                while (frm.size() > 48 - $urandom_range(0, 40)) void'(frm.pop_back());
            acc = model_accept(pf);
            if (acc) begin
                model_writes(tu);
                m_ok++;
            end else begin
                m_drop++;
            end
            prog_full = pf;
            send(tu, -1, -1, 1'b1);
            prog_full = 1'b0;
            idle($urandom_range(2, 4));
            compare_writes($sformatf("rand%0d", n));
            check_cnt($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
